// File: rtl/accel_mailbox_pkg.sv
// Shared types and constants for the CPU/accelerator mailbox buffer.
// CSR indices and CTRL/STATUS bit positions are common to RTL and software.
package accel_mailbox_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } mbox_state_t;

  localparam logic [1:0] CSR_CTRL   = 2'd0;
  localparam logic [1:0] CSR_LEN    = 2'd1;
  localparam logic [1:0] CSR_STATUS = 2'd2;
  localparam logic [1:0] CSR_IRQ_EN = 2'd3;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_CLEAR = 1;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_ERR  = 2;

  // CPU read-return pipeline stage: region select travels with the CSR value.
  typedef struct packed {
    logic        csr;
    logic        in_range;
    logic [31:0] csr_data;
  } rd_pipe_t;

endpackage

// File: rtl/accel_mailbox_ctrl.sv
// Ownership FSM, CSR bank and error/interrupt logic for the mailbox.
// Produces gated byte-write enables so only the current owner can modify the buffer.
module accel_mailbox_ctrl
  import accel_mailbox_pkg::*;
#(
  parameter int unsigned IN_DEPTH = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_csr_sel_i,
  input  logic        cpu_data_sel_i,
  input  logic [1:0]  cpu_csr_idx_i,
  input  logic [3:0]  cpu_we_i,
  input  logic [15:0] cpu_wdata_i,
  input  logic [3:0]  acc_we_i,
  input  logic        acc_done_i,
  output logic [3:0]  cpu_ram_we_o,
  output logic [3:0]  acc_ram_we_o,
  output logic [31:0] csr_rdata_o,
  output logic        acc_start_o,
  output logic [15:0] acc_len_o,
  output logic        busy_o,
  output logic        irq_o
);

  localparam logic [16:0] LenMax = 17'(4 * IN_DEPTH);

  mbox_state_t state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] acc_len_q, acc_len_d;
  logic        irq_en_q, irq_en_d;
  logic        err_q, err_d;
  logic        start_q, start_d;

  logic busy, csr_wr, ctrl_wr, start_req, clear_req, len_ok, data_wr;

  assign busy      = (state_q == StBusy);
  assign csr_wr    = cpu_csr_sel_i & (|cpu_we_i);
  assign ctrl_wr   = csr_wr & (cpu_csr_idx_i == CSR_CTRL) & cpu_we_i[0];
  assign start_req = ctrl_wr & cpu_wdata_i[CTRL_START];
  assign clear_req = ctrl_wr & cpu_wdata_i[CTRL_CLEAR];
  assign len_ok    = (len_q != '0) && ({1'b0, len_q} <= LenMax);
  assign data_wr   = cpu_data_sel_i & (|cpu_we_i);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    acc_len_d = acc_len_q;
    irq_en_d  = irq_en_q;
    err_d     = err_q;
    start_d   = 1'b0;

    if (clear_req) err_d = 1'b0;

    if (start_req) begin
      if (busy || !len_ok) begin
        err_d = 1'b1;
      end else begin
        state_d   = StBusy;
        start_d   = 1'b1;
        acc_len_d = len_q;
      end
    end else if (clear_req && state_q == StDone) begin
      state_d = StIdle;
    end

    if (busy && acc_done_i) state_d = StDone;

    if (data_wr && busy) err_d = 1'b1;

    if (csr_wr && cpu_csr_idx_i == CSR_LEN) begin
      if (busy) begin
        err_d = 1'b1;
      end else begin
        if (cpu_we_i[0]) len_d[7:0]  = cpu_wdata_i[7:0];
        if (cpu_we_i[1]) len_d[15:8] = cpu_wdata_i[15:8];
      end
    end

    if (csr_wr && cpu_csr_idx_i == CSR_IRQ_EN && cpu_we_i[0]) irq_en_d = cpu_wdata_i[0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      len_q     <= '0;
      acc_len_q <= '0;
      irq_en_q  <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      acc_len_q <= acc_len_d;
      irq_en_q  <= irq_en_d;
      err_q     <= err_d;
      start_q   <= start_d;
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    unique case (cpu_csr_idx_i)
      CSR_CTRL:   csr_rdata_o = '0;
      CSR_LEN:    csr_rdata_o[15:0] = len_q;
      CSR_STATUS: begin
        csr_rdata_o[STAT_BUSY] = busy;
        csr_rdata_o[STAT_DONE] = (state_q == StDone);
        csr_rdata_o[STAT_ERR]  = err_q;
      end
      CSR_IRQ_EN: csr_rdata_o[0] = irq_en_q;
      default:    csr_rdata_o = '0;
    endcase
  end

  assign cpu_ram_we_o = (cpu_data_sel_i && !busy) ? cpu_we_i : 4'b0000;
  assign acc_ram_we_o = busy ? acc_we_i : 4'b0000;
  assign acc_start_o  = start_q;
  assign acc_len_o    = acc_len_q;
  assign busy_o       = busy;
  assign irq_o        = (state_q == StDone) & irq_en_q;

endmodule

// File: rtl/xilinx_true_dual_port_read_first_byte_write_2_clock_ram.sv
// Byte-write, read-first true dual-port BRAM with optional output register.
// Behavioural model: both ports' writes are captured on clka, so clka and clkb must be tied.
module xilinx_true_dual_port_read_first_byte_write_2_clock_ram #(
  parameter int    NB_COL          = 4,
  parameter int    COL_WIDTH       = 8,
  parameter int    RAM_DEPTH       = 1024,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic [$clog2(RAM_DEPTH)-1:0]  addra,
  input  logic [$clog2(RAM_DEPTH)-1:0]  addrb,
  input  logic [NB_COL*COL_WIDTH-1:0]   dina,
  input  logic [NB_COL*COL_WIDTH-1:0]   dinb,
  input  logic                          clka,
  input  logic                          clkb,
  input  logic [NB_COL-1:0]             wea,
  input  logic [NB_COL-1:0]             web,
  input  logic                          ena,
  input  logic                          enb,
  input  logic                          rsta,
  input  logic                          rstb,
  input  logic                          regcea,
  input  logic                          regceb,
  output logic [NB_COL*COL_WIDTH-1:0]   douta,
  output logic [NB_COL*COL_WIDTH-1:0]   doutb
);

  logic [NB_COL*COL_WIDTH-1:0] mem [RAM_DEPTH];
  logic [NB_COL*COL_WIDTH-1:0] ram_data_a;
  logic [NB_COL*COL_WIDTH-1:0] ram_data_b;

  always_ff @(posedge clka) begin
    if (ena) begin
      ram_data_a <= mem[addra];
      for (int i = 0; i < NB_COL; i++) begin
        if (wea[i]) mem[addra][i*COL_WIDTH +: COL_WIDTH] <= dina[i*COL_WIDTH +: COL_WIDTH];
      end
    end
    if (enb) begin
      for (int i = 0; i < NB_COL; i++) begin
        if (web[i]) mem[addrb][i*COL_WIDTH +: COL_WIDTH] <= dinb[i*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  always_ff @(posedge clkb) begin
    if (enb) ram_data_b <= mem[addrb];
  end

  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
    assign douta = ram_data_a;
    assign doutb = ram_data_b;
  end else begin : g_high_perf
    logic [NB_COL*COL_WIDTH-1:0] douta_q;
    logic [NB_COL*COL_WIDTH-1:0] doutb_q;

    always_ff @(posedge clka) begin
      if (rsta)        douta_q <= '0;
      else if (regcea) douta_q <= ram_data_a;
    end

    always_ff @(posedge clkb) begin
      if (rstb)        doutb_q <= '0;
      else if (regceb) doutb_q <= ram_data_b;
    end

    assign douta = douta_q;
    assign doutb = doutb_q;
  end

endmodule

// File: rtl/accel_mailbox_mem.sv
// CPU/accelerator shared buffer: dual-port BRAM plus CSR bank and ownership control.
// Both ports return read data two cycles after the address, for data and CSR alike.
module accel_mailbox_mem
  import accel_mailbox_pkg::*;
#(
  parameter int unsigned IN_DEPTH  = 256,
  parameter int unsigned OUT_DEPTH = 256,
  parameter int unsigned ADDR_W    = $clog2(IN_DEPTH + OUT_DEPTH) + 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [ADDR_W-1:0] cpu_addr_in,
  input  logic [3:0]        cpu_we_in,
  input  logic [31:0]       cpu_data_in,
  output logic [31:0]       cpu_data_out,
  input  logic [ADDR_W-2:0] acc_addr_in,
  input  logic [3:0]        acc_we_in,
  input  logic [31:0]       acc_data_in,
  output logic [31:0]       acc_data_out,
  output logic              acc_start_out,
  output logic [15:0]       acc_len_out,
  input  logic              acc_done_in,
  output logic              busy_out,
  output logic              irq_out
);

  localparam int unsigned       Depth  = IN_DEPTH + OUT_DEPTH;
  localparam int unsigned       RamAw  = $clog2(Depth);
  localparam logic [ADDR_W-1:0] DepthW = ADDR_W'(Depth);

  logic        cpu_in_range, acc_in_range;
  logic [3:0]  cpu_ram_we, acc_ram_we;
  logic [31:0] csr_rdata, ram_douta, ram_doutb;

  rd_pipe_t    cpu_rd1_q, cpu_rd1_d, cpu_rd2_q, cpu_rd2_d;
  logic [1:0]  acc_ok_q, acc_ok_d;

  assign cpu_in_range = !cpu_addr_in[ADDR_W-1] && ({1'b0, cpu_addr_in[ADDR_W-2:0]} < DepthW);
  assign acc_in_range = ({1'b0, acc_addr_in} < DepthW);

  accel_mailbox_ctrl #(
    .IN_DEPTH (IN_DEPTH)
  ) u_ctrl (
    .clk_i          (clk_in),
    .rst_i          (rst_in),
    .cpu_csr_sel_i  (cpu_addr_in[ADDR_W-1]),
    .cpu_data_sel_i (cpu_in_range),
    .cpu_csr_idx_i  (cpu_addr_in[1:0]),
    .cpu_we_i       (cpu_we_in),
    .cpu_wdata_i    (cpu_data_in[15:0]),
    .acc_we_i       (acc_we_in & {4{acc_in_range}}),
    .acc_done_i     (acc_done_in),
    .cpu_ram_we_o   (cpu_ram_we),
    .acc_ram_we_o   (acc_ram_we),
    .csr_rdata_o    (csr_rdata),
    .acc_start_o    (acc_start_out),
    .acc_len_o      (acc_len_out),
    .busy_o         (busy_out),
    .irq_o          (irq_out)
  );

  xilinx_true_dual_port_read_first_byte_write_2_clock_ram #(
    .NB_COL          (4),
    .COL_WIDTH       (8),
    .RAM_DEPTH       (Depth),
    .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
  ) u_ram (
    .addra  (cpu_addr_in[RamAw-1:0]),
    .addrb  (acc_addr_in[RamAw-1:0]),
    .dina   (cpu_data_in),
    .dinb   (acc_data_in),
    .clka   (clk_in),
    .clkb   (clk_in),
    .wea    (cpu_ram_we),
    .web    (acc_ram_we),
    .ena    (1'b1),
    .enb    (1'b1),
    .rsta   (rst_in),
    .rstb   (rst_in),
    .regcea (1'b1),
    .regceb (1'b1),
    .douta  (ram_douta),
    .doutb  (ram_doutb)
  );

  always_comb begin
    cpu_rd1_d.csr      = cpu_addr_in[ADDR_W-1];
    cpu_rd1_d.in_range = cpu_in_range;
    cpu_rd1_d.csr_data = csr_rdata;
    cpu_rd2_d          = cpu_rd1_q;
    acc_ok_d           = {acc_ok_q[0], acc_in_range};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cpu_rd1_q <= '0;
      cpu_rd2_q <= '0;
      acc_ok_q  <= '0;
    end else begin
      cpu_rd1_q <= cpu_rd1_d;
      cpu_rd2_q <= cpu_rd2_d;
      acc_ok_q  <= acc_ok_d;
    end
  end

  assign cpu_data_out = cpu_rd2_q.csr      ? cpu_rd2_q.csr_data :
                        cpu_rd2_q.in_range ? ram_douta          : 32'h0;
  assign acc_data_out = acc_ok_q[1] ? ram_doutb : 32'h0;

endmodule

// File: doc/accel_mailbox_mem.md
Name: accel_mailbox_mem

Overview:
- Parametrised CPU↔accelerator shared buffer; successor to the fixed 256+256-word AES buffer.
- Holds an input region and an output region in one true-dual-port BRAM.
- Adds a memory-mapped CSR bank and an ownership state machine (IDLE/BUSY/DONE), so CPU and accelerator never write the same buffer concurrently.
- Drives a start pulse to the accelerator and a done interrupt to the CPU; sits between the CPU data bus and any streaming accelerator (AES first).

Parameters:
- IN_DEPTH, 256, input region depth in 32-bit words.
- OUT_DEPTH, 256, output region depth in 32-bit words.
- ADDR_W, $clog2(IN_DEPTH+OUT_DEPTH)+1, word-address width; MSB selects the CSR bank on the CPU port.

Ports:
- clk_in  input  1  single system clock for both ports.
- rst_in  input  1  synchronous active-high reset.
- cpu_addr_in  input  ADDR_W  CPU word address: data region when MSB=0, CSR when MSB=1.
- cpu_we_in  input  4  CPU byte write enables.
- cpu_data_in  input  32  CPU write data.
- cpu_data_out  output  32  CPU read data, 2-cycle latency.
- acc_addr_in  input  ADDR_W-1  accelerator word address into the data region.
- acc_we_in  input  4  accelerator byte write enables.
- acc_data_in  input  32  accelerator write data.
- acc_data_out  output  32  accelerator read data, 2-cycle latency.
- acc_start_out  output  1  one-cycle start pulse to the accelerator.
- acc_len_out  output  16  job length in bytes, stable while BUSY.
- acc_done_in  input  1  one-cycle done pulse from the accelerator.
- busy_out  output  1  high in BUSY.
- irq_out  output  1  level interrupt: DONE and IRQ_EN.

Behaviour:
- Memory map, data region: words 0..IN_DEPTH-1 are input; IN_DEPTH..IN_DEPTH+OUT_DEPTH-1 are output. Same map on both ports.
- Memory map, CSR (cpu_addr_in[ADDR_W-1]=1, index = addr[1:0]):
  - 0 CTRL: W1 pulse; bit0 START, bit1 CLEAR.
  - 1 LEN: RW, 16 bits.
  - 2 STATUS: RO; bit0 busy, bit1 done, bit2 err.
  - 3 IRQ_EN: RW, bit0.
- A CSR write requires cpu_we_in != 0. Each byte lane is honoured independently for LEN and IRQ_EN. CTRL uses lane 0 only.
- Read latency is 2 cycles on both ports (BRAM in high-performance mode). CSR reads are delayed through 2 pipeline stages, with the region select registered alongside, so cpu_data_out latency is identical for data and CSR. Addresses beyond IN_DEPTH+OUT_DEPTH read 0 and ignore writes.
- FSM states IDLE, BUSY, DONE; reset state is IDLE.
- IDLE --START & 1<=LEN<=4*IN_DEPTH--> BUSY. acc_start_out pulses exactly 1 cycle, registered, in the cycle after the CTRL write. acc_len_out latches LEN.
- START with LEN=0 or LEN>4*IN_DEPTH: err<=1, remain in current state, no pulse.
- BUSY --acc_done_in--> DONE. acc_done_in in IDLE or DONE is ignored.
- DONE --CLEAR--> IDLE. DONE --START (valid LEN)--> BUSY directly; done drops.
- START in BUSY: err<=1, ignored. CLEAR in IDLE or BUSY: no effect.
- Ownership:
  - CPU data-region writes are suppressed in BUSY and set err.
  - Accelerator writes take effect only in BUSY; outside BUSY they are dropped silently.
  - Reads are always allowed on both ports.
- LEN writes in BUSY are dropped and set err. IRQ_EN is writable in any state.
- err is sticky; it clears only on a CTRL write with bit1=1 (CLEAR), in any state.
- Simultaneous events:
  - acc_done_in in the same cycle as a blocked CPU data write: transition to DONE; the write is still suppressed and err is set.
  - Same-address CPU/accelerator write collisions cannot occur, by ownership.
- Reset values: cpu_data_out=0, acc_data_out=0 (BRAM output registers reset), acc_start_out=0, acc_len_out=0, busy_out=0, irq_out=0, LEN=0, IRQ_EN=0, err=0.
- Reset mid-operation (any state) returns to IDLE within 1 cycle. BRAM contents are preserved, not cleared.

Decomposition:
- Package accel_mailbox_pkg:
  - mbox_state_t enum (IDLE, BUSY, DONE);
  - CSR index constants CSR_CTRL=0, CSR_LEN=1, CSR_STATUS=2, CSR_IRQ_EN=3;
  - CTRL/STATUS bit-position constants.
- Sub-module accel_mailbox_ctrl holds the FSM, CSRs, err/irq logic and the write-gating outputs.
- The top level instantiates accel_mailbox_ctrl plus the existing xilinx_true_dual_port_read_first_byte_write_2_clock_ram, with RAM_DEPTH=IN_DEPTH+OUT_DEPTH, NB_COL=4, COL_WIDTH=8 and HIGH_PERFORMANCE mode.

Test Plan:
- Basic job:
  - CPU writes 0xDEADBEEF to word 5.
  - LEN=64, IRQ_EN=1, CTRL=1 → acc_start_out high exactly 1 cycle, busy_out=1, acc_len_out=64.
  - Accelerator reads word 5 → 0xDEADBEEF 2 cycles later.
  - Accelerator writes 0x12345678 to word IN_DEPTH, then pulses acc_done_in → STATUS=0b010, irq_out=1.
  - CPU reads word IN_DEPTH → 0x12345678; CTRL=2 → STATUS=0, irq_out=0.
- Ownership in BUSY:
  - CPU writes 0xAAAAAAAA to word 5 → word 5 unchanged, STATUS.err=1.
  - START again → err stays 1, no second start pulse.
  - CTRL=2 → err=0, state remains BUSY.
- Bad length:
  - LEN=0 then START → no pulse, STATUS=0b100.
  - LEN=4*IN_DEPTH+1 → same response.
  - LEN=4*IN_DEPTH → accepted.
- Outside BUSY: accelerator write in IDLE → memory unchanged; acc_done_in in IDLE → state stays IDLE, irq_out=0.
- Latency and byte enables:
  - Back-to-back CPU reads alternating data word / STATUS → each return arrives exactly 2 cycles after its address, with correct ordering.
  - Write with we=4'b0010 → only bits [15:8] change.
- Reset mid-BUSY: assert rst_in for 1 cycle → busy_out=0, STATUS=0, LEN=0, outputs 0; previously written data words are still readable afterwards.
